// File: rtl/serial_paralelo_pkg.sv
// Shared constants and FSM encoding for the serial-to-parallel byte aligner.
package serial_paralelo_pkg;

  localparam logic [7:0] BC_DEFAULT         = 8'hBC;
  localparam int         SYNC_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_shift8.sv
// 8-bit serial-in shift register; window is the 8 newest bits including the current input bit.
module serial_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] window
);

  logic [7:0] sr;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr <= 8'h00;
    end else begin
      sr <= {sr[6:0], data_in};
    end
  end

  assign window = {sr[6:0], data_in};

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel converter that hunts for comma bytes, locks byte alignment and emits data bytes.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] BC         = BC_DEFAULT,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int             CW       = $clog2(SYNC_COUNT) + 1;
  localparam logic [CW-1:0]  SYNC_MAX = CW'(SYNC_COUNT);

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] bc_cnt;
  logic [7:0]    window;
  logic          boundary;
  logic          is_bc;

  serial_shift8 u_shift (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .window  (window)
  );

  assign boundary = (bit_cnt == 3'd7);
  assign is_bc    = (window == BC);

  // valid_out: no ready side; a high level marks data_out as a fresh non-comma byte
  // for exactly one byte period, and it is only ever high while active is high.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      bit_cnt   <= 3'd0;
      bc_cnt    <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          bit_cnt <= 3'd0;
          if (is_bc) begin
            bc_cnt <= CW'(1);
            if (SYNC_MAX <= CW'(1)) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end else begin
            bc_cnt <= '0;
          end
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_bc) begin
              if (bc_cnt >= SYNC_MAX - CW'(1)) begin
                bc_cnt <= SYNC_MAX;
                state  <= ACTIVE;
                active <= 1'b1;
              end else begin
                bc_cnt <= bc_cnt + CW'(1);
              end
            end else begin
              // Misaligned comma run: restart the hunt from the next bit.
              state   <= HUNT;
              bc_cnt  <= '0;
              bit_cnt <= 3'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_bc) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= window;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state   <= HUNT;
          bit_cnt <= 3'd0;
          bc_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: lock, resync, misalignment, comma gaps and async reset.
module tb_serial_paralelo;
  import serial_paralelo_pkg::*;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int checks = 0;
  int errors = 0;

  serial_paralelo dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  // Clock / reset block
  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) send_bit(b[i]);
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (n) @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    check({tag, "_data"}, data_out, d);
    check({tag, "_valid"}, {7'd0, valid_out}, {7'd0, v});
    check({tag, "_active"}, {7'd0, active}, {7'd0, a});
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    #2;
    check_out("reset_state", 8'h00, 1'b0, 1'b0);
    check("reset_fsm", {6'd0, dut.state}, {6'd0, HUNT});
    do_reset(3);

    // Non-comma byte before lock is never presented
    send_byte(8'h77);
    check_out("prelock_77", 8'h00, 1'b0, 1'b0);

    // Basic lock then three data bytes
    repeat (3) send_byte(8'hBC);
    check_out("lock_bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check_out("lock_bc4", 8'h00, 1'b0, 1'b1);
    send_byte(8'hFF);
    check_out("data_ff", 8'hFF, 1'b1, 1'b1);
    send_byte(8'hEE);
    check_out("data_ee", 8'hEE, 1'b1, 1'b1);
    send_byte(8'hDD);
    check_out("data_dd", 8'hDD, 1'b1, 1'b1);
    send_bits(8'hAA, 4);
    check_out("hold_mid", 8'hDD, 1'b1, 1'b1);
    send_bits(8'hAA << 4, 4);
    check_out("data_aa", 8'hAA, 1'b1, 1'b1);

    // Comma gap while locked holds the last data byte
    send_byte(8'hBC);
    check_out("gap_bc", 8'hAA, 1'b0, 1'b1);
    send_byte(8'hCC);
    check_out("data_cc", 8'hCC, 1'b1, 1'b1);

    // Asynchronous reset mid-byte while locked
    send_bits(8'hE0, 3);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
    repeat (3) send_byte(8'hBC);
    check_out("relock_bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check_out("relock_bc4", 8'h00, 1'b0, 1'b1);

    // Broken comma run drops back to HUNT
    do_reset(2);
    repeat (3) send_byte(8'hBC);
    check("sync_fsm", {6'd0, dut.state}, {6'd0, SYNC});
    send_byte(8'h55);
    check("break_fsm", {6'd0, dut.state}, {6'd0, HUNT});
    check_out("break_55", 8'h00, 1'b0, 1'b0);
    repeat (3) send_byte(8'hBC);
    check_out("resync_bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check_out("resync_bc4", 8'h00, 1'b0, 1'b1);
    send_byte(8'hAA);
    check_out("resync_aa", 8'hAA, 1'b1, 1'b1);

    // Stream misaligned by three lead-in bits
    do_reset(2);
    send_bits(8'hA0, 3);
    repeat (4) send_byte(8'hBC);
    check_out("mis_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'hCC);
    check_out("mis_cc", 8'hCC, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo.md
SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 SHALL have parameter BC, default 8'hBC: the comma/idle byte.
REQ-002 SHALL have parameter SYNC_COUNT, default 4: consecutive aligned BC bytes needed for lock.
REQ-003 SHALL have port clk_32f, input, 1 bit: the single bit-rate clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, input, 1 bit: the serial stream, MSB of each byte first, one bit per clk_32f cycle.
REQ-006 SHALL have port data_out, output, 8 bits: the last non-BC byte received while locked.
REQ-007 SHALL have port valid_out, output, 1 bit: high for one byte period when data_out carries a new non-BC byte.
REQ-008 SHALL have port active, output, 1 bit: high once the block is locked to byte alignment.

Function
REQ-009 SHALL shift data_in into an 8-bit register every cycle (sr <= {sr[6:0], data_in}). The "window" is {sr[6:0], data_in}, i.e. the 8 most recent bits including the current one.
REQ-010 SHALL implement an FSM with three states: HUNT, SYNC and ACTIVE.
REQ-011 In HUNT, when the window equals BC, SHALL clear the 3-bit bit counter, set bc_cnt=1 and go to SYNC. Otherwise it stays in HUNT.
REQ-012 In SYNC and ACTIVE, the bit counter SHALL increment modulo 8 every cycle. A byte boundary is a cycle where the counter equals 7, so the next boundary is exactly 8 cycles after the HUNT detection.
REQ-013 In SYNC, at a boundary with window == BC, SHALL increment bc_cnt. When bc_cnt reaches SYNC_COUNT, SHALL go to ACTIVE with active=1 on that edge.
REQ-014 In SYNC, at a boundary with window != BC, SHALL go to HUNT, clear bc_cnt and bit counter, and not re-examine that window for BC.
REQ-015 SHALL ignore non-boundary windows in SYNC and ACTIVE.
REQ-016 In ACTIVE, at a boundary with window != BC, SHALL register data_out=window and valid_out=1 on the same edge that samples the byte's last bit (zero added latency).
REQ-017 In ACTIVE, at a boundary with window == BC, SHALL set valid_out=0 and hold data_out.
REQ-018 data_out and valid_out SHALL change only at boundaries and be held for 8 cycles (one clk_4f period).
REQ-019 SHALL never leave ACTIVE except by reset; loss-of-lock detection is out of scope.
REQ-020 valid_out SHALL be 0 whenever active is 0.
REQ-021 bc_cnt SHALL saturate at SYNC_COUNT; its width is clog2(SYNC_COUNT)+1.

Reset
REQ-022 While reset=1, SHALL asynchronously force: state=HUNT, sr=0, bit counter=0, bc_cnt=0, data_out=8'h00, valid_out=0, active=0.
REQ-023 Reset asserted mid-byte or mid-lock SHALL discard the partial byte. After release, the block SHALL require a fresh HUNT detection plus SYNC_COUNT BCs.
REQ-024 The first edge after reset release SHALL evaluate the window normally.

Structure
REQ-025 The shared package SHALL hold the BC constant 8'hBC, the SYNC_COUNT default and the state encoding HUNT=2'd0, SYNC=2'd1, ACTIVE=2'd2.
REQ-026 The 8-bit serial-in shift register with window output SHALL be a sub-module named serial_shift8; the FSM, counters and output registers SHALL stay in serial_paralelo.
REQ-027 All storage SHALL be clocked by clk_32f only; no derived clocks.

Verification
REQ-028 Send 0xBC x4 then 0xFF, 0xEE, 0xDD, MSB first. Required: active rises at the 4th BC's last bit; data_out = FF, EE, DD in successive 8-cycle periods with valid_out=1.
REQ-029 Send 3 BCs, then 0x55, then 4 BCs, then 0xAA. Required: the FSM returns to HUNT at 0x55, active=0; lock follows the later BCs, then data_out=AA, valid_out=1.
REQ-030 Send lead-in bits 3'b101 (stream misaligned by 3), then 4 BCs, then 0xCC. Required: alignment is found, and data_out=CC (not a shifted value).
REQ-031 While locked, send 0xAA, 0xBC, 0xCC. Required: valid_out is 1, then 0 with data_out held at AA, then 1 with data_out=CC.
REQ-032 Assert reset for 2 cycles mid-byte while active. Required: all outputs are 0 immediately (asynchronously); active stays 0 until 4 new aligned BCs.
REQ-033 Before lock, send a non-BC byte 0x77. Required: valid_out stays 0 and data_out stays 8'h00.
